// File: rtl/rab_l2_pkg.sv
// Shared types and entry-word layout for the L2 TLB tag-RAM programming path.
package rab_l2_pkg;

  typedef enum logic {
    OP_INSERT     = 1'b0,
    OP_INVALIDATE = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    STAT_NEW       = 2'd0,
    STAT_REPLACED  = 2'd1,
    STAT_EVICTED   = 2'd2,
    STAT_NOT_FOUND = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  localparam int unsigned FLAG_VALID  = 0;
  localparam int unsigned FLAG_RD     = 1;
  localparam int unsigned FLAG_WR     = 2;
  localparam int unsigned FLAG_MASTER = 3;
  localparam int unsigned TAG_LSB     = 4;

endpackage

// File: rtl/check_ram_writer.sv
// Inserts or invalidates one page entry in the L2 TLB tag RAM: arbitrates for
// both read ports, scans all ways of the set, then writes a single target way.
module check_ram_writer
  import rab_l2_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned RAM_DATA_WIDTH = 32,
  parameter int unsigned PAGE_SIZE      = 4096,
  parameter int unsigned SET_WIDTH      = 5,
  parameter int unsigned OFFSET_WIDTH   = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                req_valid_i,
  output logic                                req_ready_o,
  input  logic                                req_op_i,
  input  logic [ADDR_WIDTH-1:0]               req_va_i,
  input  logic                                req_master_i,
  input  logic                                req_wen_i,
  input  logic                                req_ren_i,
  output logic                                done_o,
  output logic [1:0]                          done_status_o,
  output logic [SET_WIDTH+OFFSET_WIDTH:0]     entry_addr_o,
  output logic                                ram_req_o,
  input  logic                                ram_gnt_i,
  output logic                                ram_we_o,
  output logic [SET_WIDTH+OFFSET_WIDTH:0]     port0_addr_o,
  output logic [SET_WIDTH+OFFSET_WIDTH:0]     port1_addr_o,
  output logic [RAM_DATA_WIDTH-1:0]           ram_wdata_o,
  input  logic [RAM_DATA_WIDTH-1:0]           port0_data_i,
  input  logic [RAM_DATA_WIDTH-1:0]           port1_data_i
);

  localparam int unsigned IGNORE_LSB = $clog2(PAGE_SIZE);
  localparam int unsigned IDX_W      = SET_WIDTH + OFFSET_WIDTH + 1;
  localparam int unsigned TAG_W      = RAM_DATA_WIDTH - TAG_LSB;

  // A way within the set: {half, offset}.
  typedef logic [OFFSET_WIDTH:0] way_t;

  function automatic logic [IDX_W-1:0] way_idx(input way_t w, input logic [SET_WIDTH-1:0] s);
    return {w[OFFSET_WIDTH], s, w[OFFSET_WIDTH-1:0]};
  endfunction

  state_e                    state_q, state_d;
  op_e                       op_q, op_d;
  logic [SET_WIDTH-1:0]      set_q, set_d;
  logic [TAG_W-1:0]          tag_q, tag_d;
  logic                      ren_q, ren_d;
  logic                      wen_q, wen_d;
  logic                      master_q, master_d;
  logic [OFFSET_WIDTH-1:0]   cnt_q, cnt_d;
  logic                      match_found_q, match_found_d;
  way_t                      match_way_q, match_way_d;
  logic                      free_found_q, free_found_d;
  way_t                      free_way_q, free_way_d;
  way_t                      rr_q, rr_d;
  logic [IDX_W-1:0]          target_q, target_d;
  status_e                   status_q, status_d;
  logic [RAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      do_write_q, do_write_d;

  logic                      eval_en;
  logic [OFFSET_WIDTH-1:0]   eval_off;
  logic                      hit0, hit1, free0, free1;
  logic                      m_found, f_found;
  way_t                      m_way, f_way;
  logic                      unused_bits;

  always_comb begin
    unused_bits = ^{req_va_i[IGNORE_LSB-1:0],
                    port0_data_i[TAG_LSB-1:FLAG_RD], port1_data_i[TAG_LSB-1:FLAG_RD]};
  end

  // Read data lags the issued offset by one cycle; in DRAIN cnt_q has wrapped
  // to zero, so cnt_q-1 lands on the last offset.
  always_comb begin
    eval_off = cnt_q - OFFSET_WIDTH'(1);
    eval_en  = ((state_q == S_SCAN) && (cnt_q != '0)) || (state_q == S_DRAIN);
    hit0     = port0_data_i[FLAG_VALID] && (port0_data_i[RAM_DATA_WIDTH-1:TAG_LSB] == tag_q);
    hit1     = port1_data_i[FLAG_VALID] && (port1_data_i[RAM_DATA_WIDTH-1:TAG_LSB] == tag_q);
    free0    = !port0_data_i[FLAG_VALID];
    free1    = !port1_data_i[FLAG_VALID];
  end

  // Scan trackers keep only the first hit; port0 wins at equal offset.
  always_comb begin
    m_found = match_found_q;
    m_way   = match_way_q;
    f_found = free_found_q;
    f_way   = free_way_q;
    if (eval_en) begin
      if (!match_found_q) begin
        if (hit0) begin
          m_found = 1'b1;
          m_way   = {1'b0, eval_off};
        end else if (hit1) begin
          m_found = 1'b1;
          m_way   = {1'b1, eval_off};
        end
      end
      if (!free_found_q) begin
        if (free0) begin
          f_found = 1'b1;
          f_way   = {1'b0, eval_off};
        end else if (free1) begin
          f_found = 1'b1;
          f_way   = {1'b1, eval_off};
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    set_d         = set_q;
    tag_d         = tag_q;
    ren_d         = ren_q;
    wen_d         = wen_q;
    master_d      = master_q;
    cnt_d         = cnt_q;
    match_found_d = match_found_q;
    match_way_d   = match_way_q;
    free_found_d  = free_found_q;
    free_way_d    = free_way_q;
    rr_d          = rr_q;
    target_d      = target_q;
    status_d      = status_q;
    wdata_d       = wdata_q;
    do_write_d    = do_write_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d     = op_e'(req_op_i);
          set_d    = req_va_i[IGNORE_LSB+SET_WIDTH-1:IGNORE_LSB];
          tag_d    = TAG_W'(req_va_i[ADDR_WIDTH-1:IGNORE_LSB]);
          ren_d    = req_ren_i;
          wen_d    = req_wen_i;
          master_d = req_master_i;
          state_d  = S_ARB;
        end
      end
      S_ARB: begin
        if (ram_gnt_i) begin
          cnt_d         = '0;
          match_found_d = 1'b0;
          match_way_d   = '0;
          free_found_d  = 1'b0;
          free_way_d    = '0;
          state_d       = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!ram_gnt_i) begin
          state_d = S_ARB;
        end else begin
          cnt_d         = cnt_q + OFFSET_WIDTH'(1);
          match_found_d = m_found;
          match_way_d   = m_way;
          free_found_d  = f_found;
          free_way_d    = f_way;
          if (cnt_q == '1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!ram_gnt_i) begin
          state_d = S_ARB;
        end else begin
          match_found_d = m_found;
          match_way_d   = m_way;
          free_found_d  = f_found;
          free_way_d    = f_way;
          wdata_d       = '0;
          state_d       = S_WRITE;
          if (op_q == OP_INSERT) begin
            wdata_d[RAM_DATA_WIDTH-1:TAG_LSB] = tag_q;
            wdata_d[FLAG_VALID]               = 1'b1;
            wdata_d[FLAG_RD]                  = ren_q;
            wdata_d[FLAG_WR]                  = wen_q;
            wdata_d[FLAG_MASTER]              = master_q;
            do_write_d                        = 1'b1;
            if (m_found) begin
              target_d = way_idx(m_way, set_q);
              status_d = STAT_REPLACED;
            end else if (f_found) begin
              target_d = way_idx(f_way, set_q);
              status_d = STAT_NEW;
            end else begin
              target_d = way_idx(rr_q, set_q);
              status_d = STAT_EVICTED;
              rr_d     = rr_q + way_t'(1);
            end
          end else if (m_found) begin
            target_d   = way_idx(m_way, set_q);
            status_d   = STAT_NEW;
            do_write_d = 1'b1;
          end else begin
            target_d   = way_idx('0, set_q);
            status_d   = STAT_NOT_FOUND;
            do_write_d = 1'b0;
          end
        end
      end
      S_WRITE: begin
        if (ram_gnt_i) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      op_q          <= OP_INSERT;
      set_q         <= '0;
      tag_q         <= '0;
      ren_q         <= 1'b0;
      wen_q         <= 1'b0;
      master_q      <= 1'b0;
      cnt_q         <= '0;
      match_found_q <= 1'b0;
      match_way_q   <= '0;
      free_found_q  <= 1'b0;
      free_way_q    <= '0;
      rr_q          <= '0;
      target_q      <= '0;
      status_q      <= STAT_NEW;
      wdata_q       <= '0;
      do_write_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      set_q         <= set_d;
      tag_q         <= tag_d;
      ren_q         <= ren_d;
      wen_q         <= wen_d;
      master_q      <= master_d;
      cnt_q         <= cnt_d;
      match_found_q <= match_found_d;
      match_way_q   <= match_way_d;
      free_found_q  <= free_found_d;
      free_way_q    <= free_way_d;
      rr_q          <= rr_d;
      target_q      <= target_d;
      status_q      <= status_d;
      wdata_q       <= wdata_d;
      do_write_q    <= do_write_d;
    end
  end

  always_comb begin
    req_ready_o   = (state_q == S_IDLE);
    ram_req_o     = (state_q == S_ARB) || (state_q == S_SCAN) ||
                    (state_q == S_DRAIN) || (state_q == S_WRITE);
    ram_we_o      = (state_q == S_WRITE) && ram_gnt_i && do_write_q;
    port0_addr_o  = '0;
    port1_addr_o  = '0;
    case (state_q)
      S_SCAN: begin
        port0_addr_o = {1'b0, set_q, cnt_q};
        port1_addr_o = {1'b1, set_q, cnt_q};
      end
      S_WRITE: begin
        port0_addr_o = target_q;
        port1_addr_o = target_q;
      end
      default: ;
    endcase
    ram_wdata_o   = wdata_q;
    done_o        = (state_q == S_RESP);
    done_status_o = status_q;
    entry_addr_o  = target_q;
  end

endmodule

// File: tb/tb_check_ram_writer.sv
// Directed bench for check_ram_writer with a behavioural tag-RAM and outcome model.
module tb_check_ram_writer;

  localparam logic [1:0] ST_NEW       = 2'd0;
  localparam logic [1:0] ST_REPLACED  = 2'd1;
  localparam logic [1:0] ST_EVICTED   = 2'd2;
  localparam logic [1:0] ST_NOT_FOUND = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_op_i = 1'b0;
  logic [31:0] req_va_i = '0;
  logic        req_master_i = 1'b0, req_wen_i = 1'b0, req_ren_i = 1'b0;
  logic        done_o;
  logic [1:0]  done_status_o;
  logic [9:0]  entry_addr_o;
  logic        ram_req_o;
  logic        ram_gnt_i = 1'b1;
  logic        ram_we_o;
  logic [9:0]  port0_addr_o, port1_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] p0d = '0, p1d = '0;

  always #5 clk = ~clk;

  check_ram_writer #(
    .ADDR_WIDTH(32), .RAM_DATA_WIDTH(32), .PAGE_SIZE(4096), .SET_WIDTH(5), .OFFSET_WIDTH(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_va_i(req_va_i), .req_master_i(req_master_i), .req_wen_i(req_wen_i),
    .req_ren_i(req_ren_i), .done_o(done_o), .done_status_o(done_status_o),
    .entry_addr_o(entry_addr_o), .ram_req_o(ram_req_o), .ram_gnt_i(ram_gnt_i),
    .ram_we_o(ram_we_o), .port0_addr_o(port0_addr_o), .port1_addr_o(port1_addr_o),
    .ram_wdata_o(ram_wdata_o), .port0_data_i(p0d), .port1_data_i(p1d)
  );

  int tests = 0;
  int failed = 0;
  int wr_count = 0;
  int done_count = 0;

  logic [9:0]  exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic [1:0]  exp_status = '0;
  logic        exp_write = 1'b0;
  logic [9:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic [1:0]  last_status = '0;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  // Environment tag RAM: one-cycle read latency, written by the DUT or by preloads.
  logic [31:0] ram [1024] = '{default: '0};
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  always @(posedge clk) begin
    p0d <= ram[port0_addr_o];
    p1d <= ram[port1_addr_o];
    if (ram_we_o) ram[port0_addr_o] <= ram_wdata_o;
    else if (pl_en) ram[pl_idx] <= pl_val;
  end

  // Independent model memory and round-robin pointer.
  logic [31:0] mdl_mem [1024] = '{default: '0};
  logic [4:0]  mdl_rr = '0;

  always @(negedge clk) begin
    if (ram_we_o) begin
      wr_count++;
      last_wr_addr = port0_addr_o;
      last_wr_data = ram_wdata_o;
      check("write_allowed", 32'(exp_write), 32'd1);
      check("write_addr_p0", 32'(port0_addr_o), 32'(exp_addr));
      check("write_addr_p1", 32'(port1_addr_o), 32'(exp_addr));
      check("write_data", ram_wdata_o, exp_wdata);
    end
    if (done_o) begin
      done_count++;
      last_status = done_status_o;
      check("done_status", 32'(done_status_o), 32'(exp_status));
      if (exp_status != ST_NOT_FOUND) check("entry_addr", 32'(entry_addr_o), 32'(exp_addr));
    end
  end

  task automatic model_request(input logic op, input logic [31:0] va,
                               input logic ren, input logic wen, input logic master);
    logic [19:0] page;
    logic [4:0]  set;
    int idx, mi, fi, tgt;
    page = va[31:12];
    set  = va[16:12];
    mi = -1;
    fi = -1;
    for (int off = 0; off < 16; off++) begin
      for (int h = 0; h < 2; h++) begin
        idx = h * 512 + int'(set) * 16 + off;
        if (mi < 0 && mdl_mem[idx][0] && mdl_mem[idx][31:4] == {8'h00, page}) mi = idx;
        if (fi < 0 && !mdl_mem[idx][0]) fi = idx;
      end
    end
    if (op == 1'b0) begin
      exp_write = 1'b1;
      exp_wdata = {8'h00, page, master, wen, ren, 1'b1};
      if (mi >= 0) begin
        tgt = mi; exp_status = ST_REPLACED;
      end else if (fi >= 0) begin
        tgt = fi; exp_status = ST_NEW;
      end else begin
        tgt = int'(mdl_rr[4]) * 512 + int'(set) * 16 + int'(mdl_rr[3:0]);
        exp_status = ST_EVICTED;
        mdl_rr = mdl_rr + 5'd1;
      end
      exp_addr = 10'(tgt);
      mdl_mem[tgt] = exp_wdata;
    end else begin
      exp_wdata = '0;
      if (mi >= 0) begin
        exp_write = 1'b1;
        exp_status = ST_NEW;
        exp_addr = 10'(mi);
        mdl_mem[mi] = '0;
      end else begin
        exp_write = 1'b0;
        exp_status = ST_NOT_FOUND;
      end
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
    mdl_mem[idx] = val;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_ram_req"}, 32'(ram_req_o), 32'd0);
    check({tag, "_we"}, 32'(ram_we_o), 32'd0);
    check({tag, "_p0addr"}, 32'(port0_addr_o), 32'd0);
    check({tag, "_p1addr"}, 32'(port1_addr_o), 32'd0);
    check({tag, "_wdata"}, ram_wdata_o, 32'd0);
    check({tag, "_status"}, 32'(done_status_o), 32'd0);
    check({tag, "_entry"}, 32'(entry_addr_o), 32'd0);
  endtask

  task automatic run_req(input logic op, input logic [31:0] va, input logic ren,
                         input logic wen, input logic master, input int exp_lat, input bit drop);
    int cyc, wr0, d0;
    bit seen;
    model_request(op, va, ren, wen, master);
    wr0 = wr_count;
    d0 = done_count;
    @(negedge clk);
    check("ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_op_i = op; req_va_i = va;
    req_ren_i = ren; req_wen_i = wen; req_master_i = master;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      if (cyc == 5) check("ready_busy", 32'(req_ready_o), 32'd0);
      if (drop && cyc == 11) ram_gnt_i = 1'b0;
      if (drop && cyc == 14) ram_gnt_i = 1'b1;
      if (drop && cyc == 15) check("scan_restart", 32'(port0_addr_o), 32'({1'b0, va[16:12], 4'h0}));
      if (done_o) seen = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'(exp_lat));
    @(posedge clk);
    #1;
    check("write_count", 32'(wr_count - wr0), exp_write ? 32'd1 : 32'd0);
    check("done_count", 32'(done_count - d0), 32'd1);
  endtask

  task automatic reset_mid_scan();
    int wr0, d0;
    wr0 = wr_count;
    d0 = done_count;
    exp_write = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = 1'b0; req_va_i = 32'h0008_3000;
    req_ren_i = 1'b1; req_wen_i = 1'b1; req_master_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("rst_in_scan", 32'(port0_addr_o), 32'h036);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_next");
    @(posedge clk);
    #1 rst = 1'b0;
    mdl_rr = '0;
    repeat (30) @(posedge clk);
    #1;
    check("rst_no_write", 32'(wr_count - wr0), 32'd0);
    check("rst_no_done", 32'(done_count - d0), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1 rst = 1'b0;

    // Empty set: first free way is half 0, offset 0.
    run_req(1'b0, 32'h0001_2000, 1'b1, 1'b1, 1'b0, 20, 1'b0);
    check("pin_t1_model_addr", 32'(exp_addr), 32'h120);
    check("pin_t1_addr", 32'(last_wr_addr), 32'h120);
    check("pin_t1_data", last_wr_data, 32'h0000_0127);
    check("pin_t1_status", 32'(last_status), 32'(ST_NEW));

    // Match at half 1 offset 7 wins over the free way at offset 0.
    preload(10'h120, 32'h0);
    preload(10'h327, 32'h0000_0121);
    run_req(1'b0, 32'h0001_2000, 1'b1, 1'b0, 1'b1, 20, 1'b0);
    check("pin_t2_addr", 32'(last_wr_addr), 32'h327);
    check("pin_t2_data", last_wr_data, 32'h0000_012B);
    check("pin_t2_status", 32'(last_status), 32'(ST_REPLACED));

    // Full set 3: round-robin victims 0,1,2 of half 0.
    for (int i = 0; i < 32; i++)
      preload(10'((i / 16) * 512 + 3 * 16 + (i % 16)), 32'(((32'h200 + i) << 4) | 1));
    run_req(1'b0, 32'h0000_3000, 1'b1, 1'b1, 1'b0, 20, 1'b0);
    check("pin_t3a_addr", 32'(last_wr_addr), 32'h030);
    run_req(1'b0, 32'h0002_3000, 1'b1, 1'b1, 1'b0, 20, 1'b0);
    check("pin_t3b_addr", 32'(last_wr_addr), 32'h031);
    run_req(1'b0, 32'h0004_3000, 1'b1, 1'b1, 1'b0, 20, 1'b0);
    check("pin_t3c_addr", 32'(last_wr_addr), 32'h032);
    check("pin_t3c_status", 32'(last_status), 32'(ST_EVICTED));

    // Invalidate present, then absent.
    run_req(1'b1, 32'h0002_3000, 1'b0, 1'b0, 1'b0, 20, 1'b0);
    check("pin_t4_addr", 32'(last_wr_addr), 32'h031);
    check("pin_t4_data", last_wr_data, 32'h0);
    run_req(1'b1, 32'h0005_5000, 1'b0, 1'b0, 1'b0, 20, 1'b0);
    check("pin_t4b_status", 32'(last_status), 32'(ST_NOT_FOUND));

    // Invalidated slot is reused as a free way.
    run_req(1'b0, 32'h0006_3000, 1'b1, 1'b0, 1'b0, 20, 1'b0);
    check("pin_t5_addr", 32'(last_wr_addr), 32'h031);

    // Grant dropped for 3 cycles at scan offset 9.
    preload(10'h07C, 32'h0000_0071);
    run_req(1'b0, 32'h0000_7000, 1'b0, 1'b1, 1'b1, 33, 1'b1);
    check("pin_t6_addr", 32'(last_wr_addr), 32'h07C);
    check("pin_t6_data", last_wr_data, 32'h0000_007D);

    reset_mid_scan();

    // Round-robin pointer restarts from zero after reset.
    run_req(1'b0, 32'h0008_3000, 1'b1, 1'b1, 1'b1, 20, 1'b0);
    check("pin_t7_addr", 32'(last_wr_addr), 32'h030);
    check("pin_t7_data", last_wr_data, 32'h0000_083F);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
